// File: rtl/gand_pkg.sv
// gand_pkg: shared defaults for the gand_cell block
package gand_pkg;
  localparam int GAND_WIDTH_DEF = 1;
  localparam int GAND_COUNT_W_DEF = 16;
endpackage

// File: rtl/gand_cell_sat_counter.sv
// sat_counter: saturating up-counter with sync reset and increment enable
module sat_counter
  import gand_pkg::*;
#(
  parameter int COUNT_W = GAND_COUNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inc_i,
  output logic [COUNT_W-1:0] cnt_o
);
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  // step up on enable, hold once every bit is set so the count never wraps
  always_comb cnt_d = (inc_i && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  // reset wins over any increment in the same cycle
  always_ff @(posedge clk)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/gand_cell.sv
// gand_cell: bitwise AND with registered copy, all-ones flag and high-cycle count
module gand_cell
  import gand_pkg::*;
#(
  parameter int WIDTH   = GAND_WIDTH_DEF,
  parameter int COUNT_W = GAND_COUNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [WIDTH-1:0]   y,
  output logic [WIDTH-1:0]   y_q,
  output logic               y_all,
  output logic [COUNT_W-1:0] hi_cnt
);
  logic [WIDTH-1:0] y_d, yq_q;
  // zero-latency AND path, independent of clock and reset
  always_comb y_d = a & b;
  // registered copy of the AND result, cleared by reset
  always_ff @(posedge clk)
    if (rst) yq_q <= '0;
    else yq_q <= y_d;
  assign y      = y_d;
  assign y_q    = yq_q;
  assign y_all  = &y_d;
  sat_counter #(.COUNT_W(COUNT_W)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc_i(y_d[0]),
    .cnt_o(hi_cnt)
  );
endmodule

// File: tb/tb_gand_cell.sv
// tb_gand_cell: table-driven and randomized checks of gand_cell
module tb_gand_cell;
  logic clk = 0;
  logic rst = 1;
  logic a1 = 0, b1 = 0;
  logic [3:0] a4 = 0, b4 = 0;
  logic y1, yq1, yall1, y3, yq3, yall3, yall4;
  logic [15:0] cnt1;
  logic [2:0] cnt3;
  logic [3:0] y4, yq4, cnt4;
  int checks = 0, errors = 0;
  int m_cnt1 = 0, m_cnt3 = 0, m_cnt4 = 0;
  int m_yq1 = 0, m_yq4 = 0;

  always #5 clk = ~clk;

  gand_cell u1 (.clk(clk), .rst(rst), .a(a1), .b(b1), .y(y1), .y_q(yq1), .y_all(yall1), .hi_cnt(cnt1));
  gand_cell #(.WIDTH(1), .COUNT_W(3)) u3 (.clk(clk), .rst(rst), .a(a1), .b(b1), .y(y3), .y_q(yq3), .y_all(yall3), .hi_cnt(cnt3));
  gand_cell #(.WIDTH(4), .COUNT_W(4)) u4 (.clk(clk), .rst(rst), .a(a4), .b(b4), .y(y4), .y_q(yq4), .y_all(yall4), .hi_cnt(cnt4));

  // reference: counters are plain integers clamped at their maximum
  always @(posedge clk) begin
    if (rst) begin
      m_cnt1 = 0; m_cnt3 = 0; m_cnt4 = 0; m_yq1 = 0; m_yq4 = 0;
    end else begin
      if (a1 && b1) begin
        m_cnt1 = (m_cnt1 + 1 > 65535) ? 65535 : m_cnt1 + 1;
        m_cnt3 = (m_cnt3 + 1 > 7) ? 7 : m_cnt3 + 1;
      end
      if (a4[0] && b4[0]) m_cnt4 = (m_cnt4 + 1 > 15) ? 15 : m_cnt4 + 1;
      m_yq1 = (a1 && b1) ? 1 : 0;
      m_yq4 = int'(a4 & b4);
    end
  end

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  typedef struct { logic a; logic b; logic y; } v1_t;
  typedef struct { logic [3:0] a; logic [3:0] b; logic [3:0] y; logic all; } v4_t;
  v1_t t1[4];
  v4_t t4[4];

  initial begin
    t1[0] = '{1'b0, 1'b0, 1'b0};
    t1[1] = '{1'b0, 1'b1, 1'b0};
    t1[2] = '{1'b1, 1'b0, 1'b0};
    t1[3] = '{1'b1, 1'b1, 1'b1};
    t4[0] = '{4'b1100, 4'b1010, 4'b1000, 1'b0};
    t4[1] = '{4'hF, 4'hF, 4'hF, 1'b1};
    t4[2] = '{4'b0111, 4'hF, 4'b0111, 1'b0};
    t4[3] = '{4'hF, 4'b1110, 4'b1110, 1'b0};
    rst = 1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      a1 = t1[i].a; b1 = t1[i].b;
      a4 = t4[i].a; b4 = t4[i].b;
      #1;
      check($sformatf("y1[%0d]", i), 32'(y1), 32'(t1[i].y));
      check($sformatf("yall1[%0d]", i), 32'(yall1), 32'(t1[i].y));
      check($sformatf("y4[%0d]", i), 32'(y4), 32'(t4[i].y));
      check($sformatf("yall4[%0d]", i), 32'(yall4), 32'(t4[i].all));
      #9;
    end
    a1 = 1; b1 = 1; a4 = 4'hF; b4 = 4'hF;
    step(2);
    check("reset yq1", 32'(yq1), 0);
    check("reset cnt1", 32'(cnt1), 0);
    check("reset yq4", 32'(yq4), 0);
    check("reset cnt4", 32'(cnt4), 0);
    rst = 0;
    for (int i = 1; i <= 10; i++) begin
      step(1);
      check($sformatf("run yq1@%0d", i), 32'(yq1), 1);
      check($sformatf("run cnt1@%0d", i), 32'(cnt1), 32'(i));
      check($sformatf("run cnt3@%0d", i), 32'(cnt3), 32'(i > 7 ? 7 : i));
      if (i == 1) check("yq4 full", 32'(yq4), 32'hF);
    end
    rst = 1; step(1); rst = 0;
    step(5);
    check("pre mid cnt1", 32'(cnt1), 5);
    rst = 1;
    #1 check("mid y1 in rst", 32'(y1), 1);
    step(1);
    check("mid cnt1", 32'(cnt1), 0);
    check("mid yq1", 32'(yq1), 0);
    check("mid y1", 32'(y1), 1);
    rst = 0;
    step(1);
    check("resume cnt1", 32'(cnt1), 1);
    check("resume yq1", 32'(yq1), 1);
    rst = 1; step(1); rst = 0;
    a1 = 1; b1 = 0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check($sformatf("idle cnt1@%0d", i), 32'(cnt1), 0);
      check($sformatf("idle yq1@%0d", i), 32'(yq1), 0);
    end
    for (int i = 0; i < 300; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      a1 = ($urandom_range(0, 3) != 0); b1 = ($urandom_range(0, 3) != 0);
      a4 = 4'($urandom); b4 = 4'($urandom | ($urandom_range(0, 1) ? 32'hF : 32'h0));
      #1;
      check("rnd y1", 32'(y1), 32'(a1 & b1));
      check("rnd y4", 32'(y4), 32'(a4 & b4));
      check("rnd yall4", 32'(yall4), 32'((a4 & b4) == 4'hF));
      step(1);
      check("rnd yq1", 32'(yq1), 32'(m_yq1));
      check("rnd yq4", 32'(yq4), 32'(m_yq4));
      check("rnd cnt1", 32'(cnt1), 32'(m_cnt1));
      check("rnd cnt3", 32'(cnt3), 32'(m_cnt3));
      check("rnd cnt4", 32'(cnt4), 32'(m_cnt4));
      check("rnd yq3", 32'(yq3), 32'(m_yq1));
      check("rnd yall3", 32'(yall3), 32'(y3));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
